// File: rtl/reg_file_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : reg_file_pkg
// Brief    : Shared constants, op codes and FSM states for the register file
//            sequencer.
// Revision : 1.0
// ----------------------------------------------------------------------------
package reg_file_pkg;

  localparam int DATA_W   = 16;
  localparam int ADR_W    = 3;
  localparam int NUM_REGS = 1 << ADR_W;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_FILL  = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    RESP  = 3'd3,
    FILL  = 3'd4
  } state_t;

endpackage : reg_file_pkg
`default_nettype wire

// File: rtl/reg_file_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : reg_file_sequencer
// Brief    : Command-driven initiator that serialises write, read-pair and fill
//            accesses to an 8x16 register file; all outputs registered.
// Revision : 1.0
// ----------------------------------------------------------------------------
module reg_file_sequencer #(
  parameter int DATA_W   = reg_file_pkg::DATA_W,
  parameter int ADR_W    = reg_file_pkg::ADR_W,
  parameter int NUM_REGS = reg_file_pkg::NUM_REGS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADR_W-1:0]  cmd_wadr,
  input  logic [ADR_W-1:0]  cmd_radr,
  input  logic [ADR_W-1:0]  cmd_sadr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_r,
  output logic [DATA_W-1:0] rsp_s,
  output logic [ADR_W-1:0]  rf_W_Adr,
  output logic              rf_we,
  output logic [DATA_W-1:0] rf_W,
  output logic [ADR_W-1:0]  rf_R_Adr,
  output logic [ADR_W-1:0]  rf_S_Adr,
  input  logic [DATA_W-1:0] rf_R,
  input  logic [DATA_W-1:0] rf_S
);

  import reg_file_pkg::*;

  // One extra bit so the sweep end (NUM_REGS) is distinct from address 0.
  localparam logic [ADR_W:0] c_fill_end = (ADR_W+1)'(NUM_REGS);

  state_t             r_state;
  logic               r_cmd_ready;
  logic [ADR_W:0]     r_cnt;
  logic [DATA_W-1:0]  r_seed;
  logic               r_rf_we;
  logic [ADR_W-1:0]   r_rf_w_adr;
  logic [DATA_W-1:0]  r_rf_w;
  logic [ADR_W-1:0]   r_rf_r_adr;
  logic [ADR_W-1:0]   r_rf_s_adr;
  logic               r_rsp_valid;
  logic [DATA_W-1:0]  r_rsp_r;
  logic [DATA_W-1:0]  r_rsp_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cmd_ready <= 1'b1;
      r_cnt       <= '0;
      r_seed      <= '0;
      r_rf_we     <= 1'b0;
      r_rf_w_adr  <= '0;
      r_rf_w      <= '0;
      r_rf_r_adr  <= '0;
      r_rf_s_adr  <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_r     <= '0;
      r_rsp_s     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (cmd_valid && r_cmd_ready) begin
            case (cmd_op)
              OP_WRITE: begin
                r_rf_we     <= 1'b1;
                r_rf_w_adr  <= cmd_wadr;
                r_rf_w      <= cmd_data;
                r_cmd_ready <= 1'b0;
                r_state     <= WRITE;
              end
              OP_READ: begin
                r_rf_r_adr  <= cmd_radr;
                r_rf_s_adr  <= cmd_sadr;
                r_cmd_ready <= 1'b0;
                r_state     <= READ;
              end
              OP_FILL: begin
                // Slot 0 is issued straight from the accept edge.
                r_rf_we     <= 1'b1;
                r_rf_w_adr  <= '0;
                r_rf_w      <= cmd_data;
                r_seed      <= cmd_data;
                r_cnt       <= (ADR_W+1)'(1);
                r_cmd_ready <= 1'b0;
                r_state     <= FILL;
              end
              default: begin
                r_state <= IDLE;
              end
            endcase
          end
        end

        WRITE: begin
          r_rf_we     <= 1'b0;
          r_rf_w_adr  <= '0;
          r_rf_w      <= '0;
          r_cmd_ready <= 1'b1;
          r_state     <= IDLE;
        end

        READ: begin
          r_rsp_r     <= rf_R;
          r_rsp_s     <= rf_S;
          r_rsp_valid <= 1'b1;
          r_rf_r_adr  <= '0;
          r_rf_s_adr  <= '0;
          r_state     <= RESP;
        end

        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end

        FILL: begin
          if (r_cnt == c_fill_end) begin
            r_rf_we     <= 1'b0;
            r_rf_w_adr  <= '0;
            r_rf_w      <= '0;
            r_cnt       <= '0;
            r_cmd_ready <= 1'b1;
            r_state     <= IDLE;
          end else begin
            r_rf_w_adr  <= r_cnt[ADR_W-1:0];
            r_rf_w      <= r_seed ^ DATA_W'(r_cnt[ADR_W-1:0]);
            r_cnt       <= r_cnt + (ADR_W+1)'(1);
          end
        end

        default: begin
          r_rf_we     <= 1'b0;
          r_rsp_valid <= 1'b0;
          r_cmd_ready <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_r     = r_rsp_r;
  assign rsp_s     = r_rsp_s;
  assign rf_we     = r_rf_we;
  assign rf_W_Adr  = r_rf_w_adr;
  assign rf_W      = r_rf_w;
  assign rf_R_Adr  = r_rf_r_adr;
  assign rf_S_Adr  = r_rf_s_adr;

endmodule : reg_file_sequencer
`default_nettype wire

// File: tb/tb_reg_file_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_reg_file_sequencer
// Brief    : Bench for reg_file_sequencer with an 8x16 register file model and
//            a command-level reference memory.
// Revision : 1.0
// ----------------------------------------------------------------------------
module tb_reg_file_sequencer;
  import reg_file_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADR_W-1:0]  cmd_wadr, cmd_radr, cmd_sadr;
  logic [DATA_W-1:0] cmd_data;
  logic              rsp_valid, rsp_ready;
  logic [DATA_W-1:0] rsp_r, rsp_s;
  logic [ADR_W-1:0]  rf_W_Adr, rf_R_Adr, rf_S_Adr;
  logic              rf_we;
  logic [DATA_W-1:0] rf_W, rf_R, rf_S;

  int total = 0;
  int bad   = 0;

  // Expected register contents, updated per command rather than per cycle.
  logic [DATA_W-1:0] model [NUM_REGS];
  logic [DATA_W-1:0] rf_mem [NUM_REGS];

  always #5 clk = ~clk;

  reg_file_sequencer dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_wadr(cmd_wadr), .cmd_radr(cmd_radr), .cmd_sadr(cmd_sadr),
    .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_r(rsp_r), .rsp_s(rsp_s),
    .rf_W_Adr(rf_W_Adr), .rf_we(rf_we), .rf_W(rf_W),
    .rf_R_Adr(rf_R_Adr), .rf_S_Adr(rf_S_Adr), .rf_R(rf_R), .rf_S(rf_S)
  );

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) rf_mem[i] <= '0;
    end else if (rf_we) begin
      rf_mem[rf_W_Adr] <= rf_W;
    end
  end
  assign rf_R = rf_mem[rf_R_Adr];
  assign rf_S = rf_mem[rf_S_Adr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a command and returns one step after the accept edge.
  task automatic send(input logic [1:0] op, input logic [ADR_W-1:0] w,
                      input logic [ADR_W-1:0] r, input logic [ADR_W-1:0] s,
                      input logic [DATA_W-1:0] d);
    int n;
    cmd_op = op; cmd_wadr = w; cmd_radr = r; cmd_sadr = s; cmd_data = d;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 20) begin
      tick();
      n++;
    end
    if (!cmd_ready) chk("accept_timeout", 0, 1);
    tick();
    cmd_valid = 1'b0;
    cmd_op = $urandom_range(0, 3);
    cmd_data = $urandom;
  endtask

  task automatic do_write(input logic [ADR_W-1:0] a, input logic [DATA_W-1:0] d);
    send(OP_WRITE, a, ADR_W'($urandom), ADR_W'($urandom), d);
    chk("wr_we", rf_we, 1);
    chk("wr_adr", rf_W_Adr, a);
    chk("wr_data", rf_W, d);
    chk("wr_busy", cmd_ready, 0);
    chk("wr_no_rsp", rsp_valid, 0);
    tick();
    model[a] = d;
    chk("wr_we_off", rf_we, 0);
    chk("wr_adr_idle", rf_W_Adr, 0);
    chk("wr_ready", cmd_ready, 1);
  endtask

  task automatic do_fill(input logic [DATA_W-1:0] seed);
    send(OP_FILL, ADR_W'($urandom), ADR_W'($urandom), ADR_W'($urandom), seed);
    for (int i = 0; i < NUM_REGS; i++) begin
      chk("fill_we", rf_we, 1);
      chk("fill_adr", rf_W_Adr, i);
      chk("fill_data", rf_W, seed ^ DATA_W'(i));
      chk("fill_busy", cmd_ready, 0);
      model[i] = seed ^ DATA_W'(i);
      tick();
    end
    chk("fill_we_off", rf_we, 0);
    chk("fill_ready", cmd_ready, 1);
  endtask

  // Entered one step after the READ accept edge.
  task automatic read_tail(input logic [ADR_W-1:0] r, input logic [ADR_W-1:0] s, input int hold);
    chk("rd_radr", rf_R_Adr, r);
    chk("rd_sadr", rf_S_Adr, s);
    chk("rd_busy", cmd_ready, 0);
    rsp_ready = 1'b0;
    tick();
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_r", rsp_r, model[r]);
    chk("rsp_s", rsp_s, model[s]);
    chk("rd_radr_idle", rf_R_Adr, 0);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_valid", rsp_valid, 1);
      chk("hold_r", rsp_r, model[r]);
      chk("hold_s", rsp_s, model[s]);
      chk("hold_busy", cmd_ready, 0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("rsp_clear", rsp_valid, 0);
    chk("rsp_ready_back", cmd_ready, 1);
    chk("rsp_r_kept", rsp_r, model[r]);
  endtask

  task automatic do_read(input logic [ADR_W-1:0] r, input logic [ADR_W-1:0] s, input int hold);
    send(OP_READ, ADR_W'($urandom), r, s, DATA_W'($urandom));
    read_tail(r, s, hold);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [ADR_W-1:0]  a, b;
    logic [DATA_W-1:0] d;
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = OP_NOP;
    cmd_wadr = '0; cmd_radr = '0; cmd_sadr = '0; cmd_data = '0; rsp_ready = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
    @(posedge clk); #3;
    chk("rst_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_we", rf_we, 0);
    chk("rst_wadr", rf_W_Adr, 0);
    chk("rst_w", rf_W, 0);
    chk("rst_radr", rf_R_Adr, 0);
    chk("rst_sadr", rf_S_Adr, 0);
    chk("rst_rsp_r", rsp_r, 0);
    chk("rst_rsp_s", rsp_s, 0);
    reset = 1'b0;
    tick();

    do_write(3'd3, 16'hA5A5);
    chk("rf_holds_a5a5", rf_mem[3], 16'hA5A5);
    do_fill(16'hFFFF);
    do_read(3'd2, 3'd5, 3);
    chk("read2_const", rsp_r, 16'hFFFD);
    chk("read5_const", rsp_s, 16'hFFFA);

    // Asynchronous reset in the 4th fill slot.
    send(OP_FILL, '0, '0, '0, 16'h0F0F);
    tick(); tick(); tick();
    chk("abort_slot_adr", rf_W_Adr, 3);
    #2 reset = 1'b1;
    #1;
    chk("abort_we_async", rf_we, 0);
    chk("abort_ready", cmd_ready, 1);
    @(posedge clk); #3;
    reset = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_no_writes", rf_we, 0);
    end
    do_read(3'd5, 3'd1, 1);
    chk("abort_read5", rsp_r, 16'h0000);

    // Back-to-back WRITE then READ with cmd_valid held high.
    do_write(3'd0, 16'hBEEF);
    cmd_op = OP_WRITE; cmd_wadr = 3'd7; cmd_data = 16'h1234; cmd_valid = 1'b1;
    tick();
    cmd_op = OP_READ; cmd_radr = 3'd7; cmd_sadr = 3'd0; cmd_data = 16'hDEAD;
    chk("b2b_we", rf_we, 1);
    chk("b2b_wadr", rf_W_Adr, 7);
    tick();
    model[7] = 16'h1234;
    chk("b2b_ready", cmd_ready, 1);
    chk("b2b_we_off", rf_we, 0);
    tick();
    cmd_valid = 1'b0;
    read_tail(3'd7, 3'd0, 0);
    chk("b2b_r", rsp_r, 16'h1234);
    chk("b2b_s", rsp_s, 16'hBEEF);

    // Randomised command mix, stray rsp_ready in non-read commands.
    for (int n = 0; n < 60; n++) begin
      a = ADR_W'($urandom);
      b = ADR_W'($urandom);
      d = DATA_W'($urandom);
      case ($urandom_range(0, 3))
        0: begin
          rsp_ready = 1'($urandom);
          send(OP_NOP, a, b, a, d);
          chk("nop_ready", cmd_ready, 1);
          chk("nop_we", rf_we, 0);
          chk("nop_rsp", rsp_valid, 0);
          rsp_ready = 1'b0;
        end
        1: begin
          rsp_ready = 1'($urandom);
          do_write(a, d);
          rsp_ready = 1'b0;
        end
        2: do_read(a, b, $urandom_range(0, 3));
        default: begin
          if ($urandom_range(0, 3) == 0) do_fill(d);
          else do_write(a, d);
        end
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_reg_file_sequencer
`default_nettype wire
